// File: rtl/dmem_ctrl.sv
// Data-memory sequencer: arbitrates the CPU load/store port and the DMA word port,
// and adds sub-word loads and read-modify-write sub-word stores over a word-only memory.
module dmem_ctrl #(
  parameter int unsigned MEM_BYTES = 16384,
  parameter int unsigned IDX_W     = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_t;
  typedef enum logic {GNT_CPU, GNT_DMA} gnt_t;

  state_t      state;
  gnt_t        last_grant;
  gnt_t        gnt;
  logic        l_we;
  logic [2:0]  l_f3;
  logic [1:0]  l_lane;
  logic [31:0] l_wdata;

  logic        pick_cpu, pick_dma;
  logic        sel_we, sel_err;
  logic [2:0]  sel_f3;
  logic [31:0] sel_addr, sel_wdata;
  logic [31:0] load_val, merged;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [4:0]  sh_b, sh_h;

  // DMA requests are normalised to an aligned word access so one error check serves both ports.
  always_comb begin
    pick_cpu  = cpu_req && (!dma_req || last_grant == GNT_DMA);
    pick_dma  = dma_req && !pick_cpu;
    sel_we    = pick_cpu ? cpu_we : dma_we;
    sel_f3    = pick_cpu ? cpu_funct3 : 3'b010;
    sel_addr  = pick_cpu ? cpu_addr : (dma_addr & ~32'd3);
    sel_wdata = pick_cpu ? cpu_wdata : dma_wdata;
    sel_err   = !(sel_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
             || (sel_we && sel_f3[2])
             || (sel_f3[1:0] == 2'b01 && sel_addr[0])
             || (sel_f3 == 3'b010 && sel_addr[1:0] != 2'b00)
             || (sel_addr >= MEM_BYTES);
  end

  always_comb begin
    sh_b   = {l_lane, 3'b000};
    sh_h   = {l_lane[1], 4'b0000};
    lane_b = 8'(mem_rd >> sh_b);
    lane_h = l_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (l_f3)
      3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_val = {24'h0, lane_b};
      3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_val = {16'h0, lane_h};
      default: load_val = mem_rd;
    endcase
    if (l_f3[0])
      merged = (mem_rd & ~(32'h0000_FFFF << sh_h)) | ({16'h0, l_wdata[15:0]} << sh_h);
    else
      merged = (mem_rd & ~(32'h0000_00FF << sh_b)) | ({24'h0, l_wdata[7:0]} << sh_b);
  end

  // Write enable is decoded from state so reset can kill it in the same cycle.
  assign mem_we = !rst && (state == MERGE_WR || (state == ACCESS && l_we && l_f3 == 3'b010));
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_DMA;
      gnt        <= GNT_CPU;
      l_we       <= 1'b0;
      l_f3       <= '0;
      l_lane     <= '0;
      l_wdata    <= '0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      dma_err    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      cpu_err <= 1'b0;
      dma_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_cpu || pick_dma) begin
            gnt        <= pick_cpu ? GNT_CPU : GNT_DMA;
            last_grant <= pick_cpu ? GNT_CPU : GNT_DMA;
            l_we       <= sel_we;
            l_f3       <= sel_f3;
            l_lane     <= sel_addr[1:0];
            l_wdata    <= sel_wdata;
            if (sel_err) begin
              state <= RESP;
              if (pick_cpu) begin
                cpu_ack   <= 1'b1;
                cpu_err   <= 1'b1;
                cpu_rdata <= '0;
              end else begin
                dma_ack   <= 1'b1;
                dma_err   <= 1'b1;
                dma_rdata <= '0;
              end
            end else begin
              state    <= ACCESS;
              mem_addr <= 32'({sel_addr[IDX_W+1:2], 2'b00});
              mem_wd   <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          if (l_we && l_f3 != 3'b010) begin
            mem_wd <= merged;
            state  <= MERGE_WR;
          end else begin
            state <= RESP;
            if (gnt == GNT_CPU) begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= l_we ? 32'h0 : load_val;
            end else begin
              dma_ack   <= 1'b1;
              dma_rdata <= l_we ? 32'h0 : mem_rd;
            end
          end
        end
        MERGE_WR: begin
          state     <= RESP;
          cpu_ack   <= 1'b1;
          cpu_rdata <= '0;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a behavioural 16 KB word memory.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [2:0]  cpu_funct3;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_err;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata, dma_rdata;
  logic        dma_ack, dma_err;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we, busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:4095];

  int          lat, we_cnt, we_first;
  logic [31:0] rdata;
  logic        err;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) ram[mem_addr[13:2]] <= mem_wd;
  assign mem_rd = ram[mem_addr[13:2]];

  dmem_ctrl #(.MEM_BYTES(16384), .IDX_W(12)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  // Issue one CPU request and measure ack latency and write-enable activity (lat = 0 on timeout).
  task automatic cpu_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    cpu_we = we; cpu_funct3 = f3; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    lat = 0; we_cnt = 0; we_first = 0; rdata = 'x; err = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (mem_we) begin
        we_cnt++;
        if (we_first == 0) we_first = n;
      end
      if (cpu_ack) begin
        lat = n; rdata = cpu_rdata; err = cpu_err;
        break;
      end
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic dma_op(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    dma_we = we; dma_addr = addr; dma_wdata = wd; dma_req = 1'b1;
    lat = 0; we_cnt = 0; we_first = 0; rdata = 'x; err = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (mem_we) begin
        we_cnt++;
        if (we_first == 0) we_first = n;
      end
      if (cpu_ack) begin
        errors++; $display("FAIL dma_stray_cpu_ack: got 1 expected 0");
      end
      if (dma_ack) begin
        lat = n; rdata = dma_rdata; err = dma_err;
        break;
      end
    end
    checks++;
    dma_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_funct3 = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cpu_ack, dma_ack, cpu_err, dma_err, mem_we, busy} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 000000",
                         {cpu_ack, dma_ack, cpu_err, dma_err, mem_we, busy});
    end
    checks++;
    if ({cpu_rdata, dma_rdata, mem_wd, mem_addr} !== 128'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected zeros",
                         cpu_rdata, dma_rdata, mem_wd, mem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_word;
    cpu_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_lat: got %0d expected 2", lat); end
    checks++; if (we_first !== 1 || we_cnt !== 1) begin
      errors++; $display("FAIL sw_we: got first %0d count %0d expected 1 1", we_first, we_cnt); end
    checks++; if (ram[64] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_ram: got %h expected deadbeef", ram[64]); end
    cpu_op(1'b0, 3'b010, 32'h100, 32'h0);
    checks++; if (lat !== 2 || err !== 1'b0 || we_cnt !== 0) begin
      errors++; $display("FAIL lw_lat: got lat %0d err %b we %0d expected 2 0 0", lat, err, we_cnt); end
    checks++; if (rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_data: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_rmw;
    cpu_op(1'b1, 3'b000, 32'h102, 32'hFFFFFF12);
    checks++; if (lat !== 3 || we_first !== 2 || we_cnt !== 1) begin
      errors++; $display("FAIL sb_timing: got lat %0d we_first %0d we_cnt %0d expected 3 2 1",
                         lat, we_first, we_cnt); end
    checks++; if (ram[64] !== 32'hDE12BEEF) begin
      errors++; $display("FAIL sb_ram: got %h expected de12beef", ram[64]); end
    checks++; if (rdata !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL sb_resp: got rdata %h err %b expected 0 0", rdata, err); end
    cpu_op(1'b1, 3'b001, 32'h100, 32'h1234AA55);
    checks++; if (lat !== 3 || ram[64] !== 32'hDE12AA55) begin
      errors++; $display("FAIL sh_ram: got lat %0d ram %h expected 3 de12aa55", lat, ram[64]); end
  endtask

  task automatic test_subword_loads;
    logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001};
    logic [31:0] adrs [6] = '{32'h103, 32'h103, 32'h100, 32'h102, 32'h101, 32'h102};
    logic [31:0] exps [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFAA55, 32'h0000DE12,
                              32'hFFFFFFAA, 32'hFFFFDE12};
    for (int i = 0; i < 6; i++) begin
      cpu_op(1'b0, f3s[i], adrs[i], 32'h0);
      checks++;
      if (lat !== 2 || err !== 1'b0 || rdata !== exps[i]) begin
        errors++; $display("FAIL subload_%0d: got lat %0d err %b data %h expected 2 0 %h",
                           i, lat, err, rdata, exps[i]);
      end
    end
  endtask

  task automatic test_errors;
    logic        wes  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s  [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b010, 3'b101};
    logic [31:0] adrs [6] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h4000, 32'h100};
    for (int i = 0; i < 6; i++) begin
      cpu_op(wes[i], f3s[i], adrs[i], 32'h0BAD0BAD);
      checks++;
      if (lat !== 1 || err !== 1'b1 || we_cnt !== 0 || ram[64] !== 32'hDE12AA55) begin
        errors++; $display("FAIL err_%0d: got lat %0d err %b we %0d ram %h expected 1 1 0 de12aa55",
                           i, lat, err, we_cnt, ram[64]);
      end
    end
  endtask

  task automatic test_boundary;
    cpu_op(1'b1, 3'b010, 32'h3FFC, 32'h5A5AA5A5);
    cpu_op(1'b0, 3'b010, 32'h3FFC, 32'h0);
    checks++;
    if (lat !== 2 || err !== 1'b0 || rdata !== 32'h5A5AA5A5) begin
      errors++; $display("FAIL last_word: got lat %0d err %b data %h expected 2 0 5a5aa5a5",
                         lat, err, rdata);
    end
  endtask

  task automatic test_dma;
    dma_op(1'b1, 32'h302, 32'h11223344);
    checks++; if (lat !== 2 || err !== 1'b0 || ram[192] !== 32'h11223344) begin
      errors++; $display("FAIL dma_wr: got lat %0d err %b ram %h expected 2 0 11223344",
                         lat, err, ram[192]); end
    dma_op(1'b0, 32'h301, 32'h0);
    checks++; if (lat !== 2 || rdata !== 32'h11223344) begin
      errors++; $display("FAIL dma_rd: got lat %0d data %h expected 2 11223344", lat, rdata); end
    dma_op(1'b1, 32'h4000, 32'hFFFFFFFF);
    checks++; if (lat !== 1 || err !== 1'b1 || we_cnt !== 0) begin
      errors++; $display("FAIL dma_oor: got lat %0d err %b we %0d expected 1 1 0", lat, err, we_cnt); end
  endtask

  task automatic test_arbitration;
    int exp_order [6] = '{0, 1, 0, 1, 0, 1};
    int order [6];
    int k = 0;
    int both = 0;
    logic [31:0] first_dma = '0;
    rst = 1'b1;
    cpu_we = 0; cpu_funct3 = 3'b010; cpu_addr = 32'h100; cpu_req = 1'b1;
    dma_we = 0; dma_addr = 32'h102; dma_req = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 60 && k < 6; n++) begin
      @(posedge clk); #1;
      if (cpu_ack && dma_ack) both++;
      if (cpu_ack) begin order[k] = 0; k++; end
      else if (dma_ack) begin
        if (k == 1) first_dma = dma_rdata;
        order[k] = 1; k++;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (k !== 6 || both !== 0) begin
      errors++; $display("FAIL arb_count: got acks %0d dual %0d expected 6 0", k, both); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (order[i] !== exp_order[i]) begin
        errors++; $display("FAIL arb_order_%0d: got %0d expected %0d (0=cpu 1=dma)",
                           i, order[i], exp_order[i]);
      end
    end
    checks++; if (first_dma !== 32'hDE12AA55) begin
      errors++; $display("FAIL arb_dma_data: got %h expected de12aa55", first_dma); end
  endtask

  task automatic test_reset_mid_rmw;
    int stray = 0;
    cpu_op(1'b1, 3'b010, 32'h200, 32'hCAFEF00D);
    cpu_we = 1'b1; cpu_funct3 = 3'b000; cpu_addr = 32'h200; cpu_wdata = 32'h77; cpu_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_we !== 1'b1) begin
      errors++; $display("FAIL rmw_merge_we: got %b expected 1", mem_we); end
    rst = 1'b1; cpu_req = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_gate_we: got %b expected 0", mem_we); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || cpu_ack !== 1'b0 || ram[128] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rst_abort: got busy %b ack %b ram %h expected 0 0 cafef00d",
                         busy, cpu_ack, ram[128]); end
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cpu_ack || dma_ack || busy) stray++;
    end
    checks++; if (stray !== 0) begin
      errors++; $display("FAIL rst_quiet: got %0d active cycles expected 0", stray); end
  endtask

  initial begin
    test_reset;
    test_word;
    test_rmw;
    test_subword_loads;
    test_errors;
    test_boundary;
    test_dma;
    test_arbitration;
    test_reset_mid_rmw;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
